pipe_drawer: RTL and testbench
==============================

// Module: pipe_drawer
// PURPOSE
//  Downstream consumer of the pipe position register. On each game tick it takes the
//  pipe's x (left edge) and gap top y, and renders the one-pixel move to the VGA adapter.
//  It erases the column the pipe just vacated (trailing edge), then paints the new
//  leading column, leaving the gap background-coloured. One pixel is plotted per clock.
// PARAMETERS
//  SCREEN_W     160     visible columns; columns >= SCREEN_W are never plotted
//  SCREEN_H     120     visible rows; each column pass is SCREEN_H pixels
//  PIPE_W       8       pipe width in pixels; trailing column = x + PIPE_W
//  GAP_H        20      opening height; gap rows = [gap_y, gap_y+GAP_H-1]
//  PIPE_COLOUR  3'b010  colour of pipe body
//  BG_COLOUR    3'b000  background / erase colour
// PORTS
//  CLOCK_50  in   1  system clock; everything runs on its rising edge
//  reset     in   1  asynchronous, active-high reset
//  start     in   1  one-cycle pulse, synchronous to CLOCK_50, from the game-tick logic
//  pipe_x    in   8  pipe left edge (valid when start=1)
//  gap_y     in   7  top row of the opening (valid when start=1)
//  busy      out  1  high from the cycle after start is accepted until done
//  done      out  1  one-cycle pulse when the frame update completes
//  vga_x     out  8  pixel column to the VGA adapter
//  vga_y     out  7  pixel row to the VGA adapter
//  colour    out  3  pixel colour
//  plot      out  1  write enable to the VGA adapter; the pixel is written when high
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy=0, done=0, plot=0, vga_x=0, vga_y=0, colour=BG_COLOUR;
//    latched x/gap and row counter cleared. Reset mid-pass abandons the pass; no further plot.
//  - FSM: IDLE -> ERASE -> DRAW -> FINISH -> IDLE.
//    IDLE: start=1 latches pipe_x, gap_y; next state ERASE, row=0. Otherwise stays in IDLE.
//    ERASE: column ce = {1'b0,x_l} + PIPE_W (9-bit); rows 0..SCREEN_H-1, colour=BG_COLOUR.
//      At row SCREEN_H-1 -> DRAW, row=0.
//    DRAW: column cd = {1'b0,x_l}; row r gets BG_COLOUR if gap_y<=r<=gap_y+GAP_H-1
//      (8-bit compare, no wrap), else PIPE_COLOUR. At row SCREEN_H-1 -> FINISH.
//    FINISH: done=1 for exactly one cycle; busy=0; next state IDLE.
//  - Outputs are registered. vga_x/vga_y/colour/plot present the pixel in the same cycle
//    the FSM is in that row. plot=1 only in ERASE/DRAW and only if column < SCREEN_W;
//    off-screen columns still take SCREEN_H cycles, so timing does not depend on x.
//  - Timing: start sampled at edge 0; first plot at cycle 1; done high at cycle
//    2*SCREEN_H+1 (241 with defaults); busy high in cycles 1..2*SCREEN_H.
//  - start while busy or during FINISH is ignored, with no queueing. Inputs are sampled
//    only at acceptance.
//  - Boundaries: x=160 -> nothing plotted. x=255 (underflowed) -> nothing plotted.
//    x=152 -> erase column 160 suppressed, draw column 152 plotted.
//    gap_y+GAP_H > SCREEN_H -> gap truncated at the bottom. gap_y >= SCREEN_H -> no gap.
// STRUCTURE
//  - Shared package/header: SCREEN_W, SCREEN_H, PIPE_W, GAP_H, colour constants, shared
//    with the position register and collision logic. FSM state encodings are local.
//  - One sub-module: column_scanner (row counter 0..SCREEN_H-1 with enable, last_row
//    flag). It is reused for ERASE and DRAW. The FSM and colour select live at the top level.
// TESTING
//  1. Reset held, then released with no start -> plot=0, busy=0, done=0, colour=000 forever.
//  2. start, x=100, gap_y=50 -> 120 plots at x=108 colour 000; then 120 plots at x=100,
//     rows 50..69 colour 000, other rows 010; done at cycle 241.
//  3. start, x=152, gap_y=0 -> no plot in ERASE (column 160); DRAW rows 0..19 colour 000,
//     rows 20..119 colour 010; done still at 241.
//  4. start, x=160, then x=255 -> plot never asserted; busy/done timing identical to case 2.
//  5. Second start at cycle 10 of a pass -> ignored, exactly one done. start at cycle 242
//     -> accepted normally.
//  6. Assert reset at cycle 60 of a pass -> plot/busy drop at once, no done. A fresh start
//     after release gives the full 241-cycle sequence. Also gap_y=110: rows 110..119 are
//     gap, with no wrap to row 0.

Source files
------------

// File: rtl/pipe_drawer_pkg.sv
// Shared screen geometry and colour constants for the pipe datapath
// (position register, drawer, collision logic), plus the small helpers
// the drawer uses to pick pixel colours and decide whether a column is visible.
package pipe_drawer_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned PIPE_W   = 8;
  localparam int unsigned GAP_H    = 20;

  typedef logic [2:0] colour_t;

  localparam colour_t PIPE_COLOUR = 3'b010;
  localparam colour_t BG_COLOUR   = 3'b000;

  // Columns are carried at 9 bits so x + PIPE_W never wraps back on screen.
  function automatic logic on_screen(input logic [8:0] col);
    return col < 9'(SCREEN_W);
  endfunction

  // 8-bit compare so a gap that runs past the bottom is truncated rather than
  // wrapping to row 0.
  function automatic colour_t row_colour(input logic [6:0] row, input logic [6:0] gap);
    logic [7:0] top;
    logic [7:0] bot;
    logic [7:0] r;
    top = {1'b0, gap};
    bot = top + 8'(GAP_H - 1);
    r   = {1'b0, row};
    return (r >= top && r <= bot) ? BG_COLOUR : PIPE_COLOUR;
  endfunction

endpackage

// File: rtl/pipe_drawer_if.sv
// Handshake and VGA pixel bus between the game-tick logic, the pipe drawer
// and the VGA adapter.
//  start/pipe_x/gap_y : request from game-tick logic (master drives)
//  busy/done          : drawer status (slave drives)
//  vga_x/vga_y/colour/plot : pixel write to the VGA adapter (slave drives)
interface pipe_drawer_if;
  import pipe_drawer_pkg::*;

  logic       start;
  logic [7:0] pipe_x;
  logic [6:0] gap_y;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  colour_t    colour;
  logic       plot;

  modport master (
    output start, pipe_x, gap_y,
    input  busy, done, vga_x, vga_y, colour, plot
  );

  modport slave (
    input  start, pipe_x, gap_y,
    output busy, done, vga_x, vga_y, colour, plot
  );

endinterface

// File: rtl/pipe_drawer_column_scanner.sv
// Row counter for one column pass of the pipe drawer.
//  i_clk, i_rst : clock, asynchronous active-high reset
//  i_clr        : restart at row 0 (wins over i_en)
//  i_en         : advance one row
//  o_row        : current row, 0..SCREEN_H-1
//  o_last       : o_row is the final row of the column
module pipe_drawer_column_scanner
  import pipe_drawer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [6:0] o_row,
  output logic       o_last
);

  logic [6:0] r_row;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row <= '0;
    end else if (i_clr) begin
      r_row <= '0;
    end else if (i_en) begin
      r_row <= r_row + 7'd1;
    end
  end

  assign o_row  = r_row;
  assign o_last = (r_row == 7'(SCREEN_H - 1));

endmodule

// File: rtl/pipe_drawer.sv
// Pipe drawer: on a start pulse, erases the column the pipe just vacated
// (x + PIPE_W) and paints the new leading column x, leaving the gap in the
// background colour. One pixel per clock; off-screen columns still take the
// full SCREEN_H cycles but are not plotted.
//  CLOCK_50 : system clock
//  reset    : asynchronous active-high reset
//  bus      : pipe_drawer_if.slave (start/pipe_x/gap_y in; busy/done and VGA pixel out)
module pipe_drawer
  import pipe_drawer_pkg::*;
(
  input logic          CLOCK_50,
  input logic          reset,
  pipe_drawer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_FINISH} state_t;

  state_t     r_state;
  logic [7:0] r_x;
  logic [6:0] r_gap;
  logic       r_busy;
  logic       r_done;
  logic       r_plot;
  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  colour_t    r_colour;

  logic       w_clr;
  logic       w_en;
  logic [6:0] w_row;
  logic       w_last;
  logic [6:0] w_row_nxt;
  logic [8:0] w_ce_in;
  logic [8:0] w_cd;

  pipe_drawer_column_scanner u_scanner (
    .i_clk  (CLOCK_50),
    .i_rst  (reset),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_row  (w_row),
    .o_last (w_last)
  );

  always_comb begin
    w_clr = 1'b0;
    w_en  = 1'b0;
    case (r_state)
      S_IDLE:           w_clr = bus.start;
      S_ERASE, S_DRAW: begin
        w_clr = w_last;
        w_en  = ~w_last;
      end
      default: ;
    endcase
  end

  assign w_row_nxt = w_row + 7'd1;
  assign w_ce_in   = {1'b0, bus.pipe_x} + 9'(PIPE_W);
  assign w_cd      = {1'b0, r_x};

  // Pixel outputs are loaded from the row the scanner moves to on the same
  // edge, so the registered pixel always matches the scanner's current row.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_gap    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_plot   <= 1'b0;
      r_vga_x  <= '0;
      r_vga_y  <= '0;
      r_colour <= BG_COLOUR;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x      <= bus.pipe_x;
            r_gap    <= bus.gap_y;
            r_state  <= S_ERASE;
            r_busy   <= 1'b1;
            r_vga_x  <= w_ce_in[7:0];
            r_vga_y  <= '0;
            r_colour <= BG_COLOUR;
            r_plot   <= on_screen(w_ce_in);
          end
        end
        S_ERASE: begin
          if (w_last) begin
            r_state  <= S_DRAW;
            r_vga_x  <= r_x;
            r_vga_y  <= '0;
            r_colour <= row_colour('0, r_gap);
            r_plot   <= on_screen(w_cd);
          end else begin
            r_vga_y <= w_row_nxt;
          end
        end
        S_DRAW: begin
          if (w_last) begin
            r_state  <= S_FINISH;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_plot   <= 1'b0;
            r_colour <= BG_COLOUR;
          end else begin
            r_vga_y  <= w_row_nxt;
            r_colour <= row_colour(w_row_nxt, r_gap);
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.plot   = r_plot;
  assign bus.vga_x  = r_vga_x;
  assign bus.vga_y  = r_vga_y;
  assign bus.colour = r_colour;

endmodule

// File: tb/tb_pipe_drawer.sv
// Directed bench for pipe_drawer: a table of passes with hand-counted plot
// totals, a per-cycle pixel/handshake model, and hand-written sequences for
// reset behaviour and a reset in the middle of a pass.
module tb_pipe_drawer;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  pipe_drawer_if bus ();

  pipe_drawer dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] gap;
    int         mode;       // 0 plain pass, 1 with ignored starts at cycles 10 and 241
    int         exp_erase;  // plots while erasing
    int         exp_draw;   // plots while drawing
    int         exp_gap;    // draw plots in background colour
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called right after a negedge: start is sampled at the next posedge (edge 0).
  task automatic run_pass(input int idx, input logic [7:0] x, input logic [6:0] gap,
                          input int mode, input int exp_e, input int exp_d, input int exp_g);
    int ce, e_busy, e_done, e_plot, e_x, e_y, e_col;
    int n_e, n_d, n_g, n_done;
    n_e = 0; n_d = 0; n_g = 0; n_done = 0;
    ce = int'(x) + 8;
    bus.start  = 1'b1;
    bus.pipe_x = x;
    bus.gap_y  = gap;
    for (int c = 1; c <= 242; c++) begin
      @(negedge CLOCK_50);
      bus.start = 1'b0;
      if (mode == 1 && (c == 10 || c == 241)) begin
        bus.start  = 1'b1;
        bus.pipe_x = 8'd3;
        bus.gap_y  = 7'd0;
      end
      e_x = 0; e_y = 0; e_col = 0;
      if (c <= 120) begin
        e_busy = 1; e_plot = (ce < 160) ? 1 : 0; e_x = ce % 256; e_y = c - 1;
      end else if (c <= 240) begin
        e_busy = 1; e_plot = (int'(x) < 160) ? 1 : 0; e_x = int'(x); e_y = c - 121;
        e_col = (e_y >= int'(gap) && e_y < int'(gap) + 20) ? 0 : 2;
      end else begin
        e_busy = 0; e_plot = 0;
      end
      e_done = (c == 241) ? 1 : 0;
      chk($sformatf("v%0d c%0d busy", idx, c), int'(bus.busy), e_busy);
      chk($sformatf("v%0d c%0d done", idx, c), int'(bus.done), e_done);
      chk($sformatf("v%0d c%0d plot", idx, c), int'(bus.plot), e_plot);
      if (e_plot == 1) begin
        chk($sformatf("v%0d c%0d vga_x", idx, c), int'(bus.vga_x), e_x);
        chk($sformatf("v%0d c%0d vga_y", idx, c), int'(bus.vga_y), e_y);
        chk($sformatf("v%0d c%0d colour", idx, c), int'(bus.colour), e_col);
      end
      if (bus.done) n_done++;
      if (bus.plot && c <= 120) n_e++;
      if (bus.plot && c > 120) begin
        n_d++;
        if (bus.colour == 3'b000) n_g++;
      end
    end
    chk($sformatf("v%0d erase plots", idx), n_e, exp_e);
    chk($sformatf("v%0d draw plots", idx), n_d, exp_d);
    chk($sformatf("v%0d gap plots", idx), n_g, exp_g);
    chk($sformatf("v%0d done pulses", idx), n_done, 1);
  endtask

  initial begin
    vecs[0] = '{x: 8'd100, gap: 7'd50,  mode: 0, exp_erase: 120, exp_draw: 120, exp_gap: 20};
    vecs[1] = '{x: 8'd152, gap: 7'd0,   mode: 0, exp_erase: 0,   exp_draw: 120, exp_gap: 20};
    vecs[2] = '{x: 8'd160, gap: 7'd50,  mode: 0, exp_erase: 0,   exp_draw: 0,   exp_gap: 0};
    vecs[3] = '{x: 8'd255, gap: 7'd50,  mode: 0, exp_erase: 0,   exp_draw: 0,   exp_gap: 0};
    vecs[4] = '{x: 8'd40,  gap: 7'd30,  mode: 1, exp_erase: 120, exp_draw: 120, exp_gap: 20};
    vecs[5] = '{x: 8'd0,   gap: 7'd120, mode: 0, exp_erase: 120, exp_draw: 120, exp_gap: 0};
    vecs[6] = '{x: 8'd151, gap: 7'd127, mode: 0, exp_erase: 120, exp_draw: 120, exp_gap: 0};

    bus.start  = 1'b0;
    bus.pipe_x = '0;
    bus.gap_y  = '0;

    // Outputs while reset is held.
    repeat (3) @(negedge CLOCK_50);
    chk("rst plot",   int'(bus.plot),   0);
    chk("rst busy",   int'(bus.busy),   0);
    chk("rst done",   int'(bus.done),   0);
    chk("rst vga_x",  int'(bus.vga_x),  0);
    chk("rst vga_y",  int'(bus.vga_y),  0);
    chk("rst colour", int'(bus.colour), 0);
    reset = 1'b0;

    // Idle with no start.
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      chk($sformatf("idle%0d plot", i),   int'(bus.plot),   0);
      chk($sformatf("idle%0d busy", i),   int'(bus.busy),   0);
      chk($sformatf("idle%0d done", i),   int'(bus.done),   0);
      chk($sformatf("idle%0d colour", i), int'(bus.colour), 0);
    end

    // Vector 4 ends at cycle 242 and vector 5 starts there, so that start is
    // sampled on the first IDLE edge after FINISH.
    for (int v = 0; v < 7; v++)
      run_pass(v, vecs[v].x, vecs[v].gap, vecs[v].mode,
               vecs[v].exp_erase, vecs[v].exp_draw, vecs[v].exp_gap);

    // Reset at cycle 60 of a pass abandons it.
    bus.start  = 1'b1;
    bus.pipe_x = 8'd100;
    bus.gap_y  = 7'd50;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    for (int c = 2; c <= 60; c++) @(negedge CLOCK_50);
    chk("pre-rst busy", int'(bus.busy), 1);
    chk("pre-rst plot", int'(bus.plot), 1);
    reset = 1'b1;
    #1;
    chk("midrst plot", int'(bus.plot), 0);
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst done", int'(bus.done), 0);
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLOCK_50);
      chk($sformatf("postrst%0d plot", i), int'(bus.plot), 0);
      chk($sformatf("postrst%0d busy", i), int'(bus.busy), 0);
      chk($sformatf("postrst%0d done", i), int'(bus.done), 0);
    end

    // Fresh pass after reset, gap reaching past the bottom row.
    run_pass(7, 8'd60, 7'd110, 0, 120, 120, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
